// File: rtl/chess_pkg.sv
// chess_pkg: shared definitions for the chess board video path.
// Holds piece/colour codes, 640x480@60 VGA timing constants, the RGB
// palette used by the renderer and a small square-shading helper.
package chess_pkg;

    // Piece codes as stored in the low three bits of a board entry.
    localparam logic [2:0] PIECE_NONE   = 3'd0;
    localparam logic [2:0] PIECE_PAWN   = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT = 3'd2;
    localparam logic [2:0] PIECE_BISHOP = 3'd3;
    localparam logic [2:0] PIECE_ROOK   = 3'd4;
    localparam logic [2:0] PIECE_QUEEN  = 3'd5;
    localparam logic [2:0] PIECE_KING   = 3'd6;

    // Colour bit, stored as bit 3 of a board entry.
    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    // VGA 640x480@60 timing, in pixels and lines.
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Glyph area inside a square: 32x32 pixels, each glyph bit is 4x4 pixels.
    localparam logic [5:0] GLYPH_LO = 6'd12;
    localparam logic [5:0] GLYPH_HI = 6'd43;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t RGB_OFF         = {3'd0, 3'd0, 2'd0};
    localparam rgb_t RGB_CURSOR      = {3'd7, 3'd7, 2'd0};
    localparam rgb_t RGB_WHITE_PIECE = {3'd7, 3'd7, 2'd3};
    localparam rgb_t RGB_BLACK_PIECE = {3'd0, 3'd0, 2'd0};
    localparam rgb_t RGB_SELECTED    = {3'd0, 3'd5, 2'd0};
    localparam rgb_t RGB_LIGHT_SQ    = {3'd6, 3'd5, 2'd2};
    localparam rgb_t RGB_DARK_SQ     = {3'd3, 3'd2, 2'd0};

    // A square is light when row and column have equal parity (row^col even).
    function automatic logic square_is_light(input logic [2:0] row, input logic [2:0] col);
        return (row[0] == col[0]);
    endfunction

endpackage

// File: rtl/piece_glyph_rom.sv
// piece_glyph_rom: 8x8 piece bitmaps, one row per lookup (combinational).
// Ports: piece     - piece code (PIECE_*)
//        glyph_row - glyph row 0..7, row 0 at the top
//        row_bits  - bitmap row, bit 7 is the leftmost glyph column
// Empty squares and the unused code 7 return an all-zero row.
module piece_glyph_rom
    import chess_pkg::*;
(
    input  logic [2:0] piece,
    input  logic [2:0] glyph_row,
    output logic [7:0] row_bits
);

    logic [63:0] glyph_s;

    // Whole-glyph select; row 0 lives in the top byte.
    always_comb begin
        glyph_s = 64'h0;
        case (piece)
            PIECE_PAWN:   glyph_s = 64'h0000_183C_183C_7E00;
            PIECE_KNIGHT: glyph_s = 64'h0038_7C6C_1C3C_7E00;
            PIECE_BISHOP: glyph_s = 64'h183C_2C3C_183C_7E00;
            PIECE_ROOK:   glyph_s = 64'h5A7E_3C3C_3C3C_7E00;
            PIECE_QUEEN:  glyph_s = 64'h5A5A_7E3C_3C3C_7E00;
            PIECE_KING:   glyph_s = 64'h187E_183C_3C3C_7E00;
            default:      glyph_s = 64'h0;
        endcase
    end

    // Row r sits at bit offset (7-r)*8; ~glyph_row equals 7-r for 3 bits.
    assign row_bits = glyph_s[{~glyph_row, 3'b000} +: 8];

endmodule

// File: rtl/board_vga_renderer.sv
// board_vga_renderer: 640x480@60 raster generator that draws the chess board.
// Ports: CLK/RESET (async active-low), board_read_addr/board_read_data
//        (one square fetched at a time), cursor_addr, selected_piece_addr,
//        hilite_selected_square (latched once per frame), vga_hsync/vga_vsync
//        (active low), vga_r/g/b, frame_tick (pulse at line 480, pixel 0).
// Three pipeline stages: fetch address, board data + glyph row, colour.
// Every output is delayed by exactly 3 cycles relative to the counters.
module board_vga_renderer
    import chess_pkg::*;
#(
    parameter int X0     = 96,
    parameter int Y0     = 16,
    parameter int SQ     = 56,
    parameter int BORDER = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic [5:0] board_read_addr,
    input  logic [3:0] board_read_data,
    input  logic [5:0] cursor_addr,
    input  logic [5:0] selected_piece_addr,
    input  logic       hilite_selected_square,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic       frame_tick
);

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_L   = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L   = 10'(V_VIS);
    localparam logic [9:0] HS_START  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] X0_L      = 10'(X0);
    localparam logic [9:0] X1_L      = 10'(X0 + 8 * SQ);
    localparam logic [9:0] Y0_L      = 10'(Y0);
    localparam logic [9:0] Y1_L      = 10'(Y0 + 8 * SQ);
    localparam logic [5:0] SQ_LAST   = 6'(SQ - 1);
    localparam logic [5:0] BORDER_LO = 6'(BORDER);
    localparam logic [5:0] BORDER_HI = 6'(SQ - BORDER);

    logic [9:0] h_r, v_r, h_next_s, v_next_s;
    logic [5:0] px_r, py_r;
    logic [2:0] col_r, row_r;
    logic       in_board_s, visible_s, hsync_s, vsync_s, tick_s;

    // Stage 1 / stage 2 pipeline state.
    logic [5:0] px1_r, py1_r, sq1_r, px2_r, py2_r, sq2_r;
    logic       in_board1_r, vis1_r, hs1_r, vs1_r, tick1_r;
    logic       in_board2_r, vis2_r, hs2_r, vs2_r, tick2_r;
    logic [3:0] entry2_r;
    logic [7:0] glyph2_r, rom_row_s;
    logic [5:0] py1_off_s, gx_s;

    // Per-frame latched overlay state.
    logic [5:0] cursor_lat_r, selected_lat_r;
    logic       hilite_lat_r;

    logic       in_glyph_s, glyph_bit_s, border_s;
    rgb_t       pix_s;

    // Next raster position: h wraps at 799, v steps on each h wrap.
    always_comb begin
        h_next_s = h_r + 10'd1;
        v_next_s = v_r;
        if (h_r == H_LAST) begin
            h_next_s = 10'd0;
            if (v_r == V_LAST) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = v_r + 10'd1;
            end
        end else begin
            v_next_s = v_r;
        end
    end

    // Raster counters plus divider-free square/sub-pixel trackers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            h_r   <= 10'd0;
            v_r   <= 10'd0;
            px_r  <= 6'd0;
            py_r  <= 6'd0;
            col_r <= 3'd0;
            row_r <= 3'd0;
        end else begin
            h_r <= h_next_s;
            v_r <= v_next_s;
            // Restart on the cycle the counter reaches the board edge so px==0 at h==X0.
            if (h_next_s == X0_L) begin
                px_r  <= 6'd0;
                col_r <= 3'd0;
            end else if (px_r == SQ_LAST) begin
                px_r  <= 6'd0;
                col_r <= col_r + 3'd1;
            end else begin
                px_r <= px_r + 6'd1;
            end
            if (h_r == H_LAST) begin
                if (v_next_s == Y0_L) begin
                    py_r  <= 6'd0;
                    row_r <= 3'd0;
                end else if (py_r == SQ_LAST) begin
                    py_r  <= 6'd0;
                    row_r <= row_r + 3'd1;
                end else begin
                    py_r <= py_r + 6'd1;
                end
            end
        end
    end

    assign in_board_s = (h_r >= X0_L) && (h_r < X1_L) && (v_r >= Y0_L) && (v_r < Y1_L);
    assign visible_s  = (h_r < H_VIS_L) && (v_r < V_VIS_L);
    assign hsync_s    = !((h_r >= HS_START) && (h_r < HS_END));
    assign vsync_s    = !((v_r >= VS_START) && (v_r < VS_END));
    assign tick_s     = (h_r == 10'd0) && (v_r == V_VIS_L);

    // Glyph row comes from the stage-1 line offset; garbage outside the glyph area is masked later.
    assign py1_off_s = py1_r - GLYPH_LO;

    piece_glyph_rom u_glyph_rom (
        .piece     (board_read_data[2:0]),
        .glyph_row (py1_off_s[4:2]),
        .row_bits  (rom_row_s)
    );

    // Stage 1 and stage 2 registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            board_read_addr <= 6'd0;
            px1_r <= 6'd0;  py1_r <= 6'd0;  sq1_r <= 6'd0;
            in_board1_r <= 1'b0;  vis1_r <= 1'b0;
            hs1_r <= 1'b1;  vs1_r <= 1'b1;  tick1_r <= 1'b0;
            px2_r <= 6'd0;  py2_r <= 6'd0;  sq2_r <= 6'd0;
            in_board2_r <= 1'b0;  vis2_r <= 1'b0;
            hs2_r <= 1'b1;  vs2_r <= 1'b1;  tick2_r <= 1'b0;
            entry2_r <= 4'd0;  glyph2_r <= 8'd0;
        end else begin
            // Address parks at 0 off-board so it only moves at square boundaries.
            board_read_addr <= in_board_s ? {row_r, col_r} : 6'd0;
            px1_r <= px_r;  py1_r <= py_r;  sq1_r <= {row_r, col_r};
            in_board1_r <= in_board_s;  vis1_r <= visible_s;
            hs1_r <= hsync_s;  vs1_r <= vsync_s;  tick1_r <= tick_s;
            px2_r <= px1_r;  py2_r <= py1_r;  sq2_r <= sq1_r;
            in_board2_r <= in_board1_r;  vis2_r <= vis1_r;
            hs2_r <= hs1_r;  vs2_r <= vs1_r;  tick2_r <= tick1_r;
            entry2_r <= board_read_data;
            glyph2_r <= rom_row_s;
        end
    end

    assign gx_s        = px2_r - GLYPH_LO;
    assign glyph_bit_s = glyph2_r[~gx_s[4:2]];
    assign in_glyph_s  = (px2_r >= GLYPH_LO) && (px2_r <= GLYPH_HI) &&
                         (py2_r >= GLYPH_LO) && (py2_r <= GLYPH_HI);
    assign border_s    = (px2_r < BORDER_LO) || (px2_r >= BORDER_HI) ||
                         (py2_r < BORDER_LO) || (py2_r >= BORDER_HI);

    // Pixel colour by priority: blank, cursor border, glyph, selection, square.
    always_comb begin
        pix_s = RGB_OFF;
        if (!vis2_r || !in_board2_r) begin
            pix_s = RGB_OFF;
        end else if ((sq2_r == cursor_lat_r) && border_s) begin
            pix_s = RGB_CURSOR;
        end else if (in_glyph_s && glyph_bit_s) begin
            pix_s = (entry2_r[3] == COLOR_WHITE) ? RGB_WHITE_PIECE : RGB_BLACK_PIECE;
        end else if (hilite_lat_r && (sq2_r == selected_lat_r)) begin
            pix_s = RGB_SELECTED;
        end else if (square_is_light(sq2_r[5:3], sq2_r[2:0])) begin
            pix_s = RGB_LIGHT_SQ;
        end else begin
            pix_s = RGB_DARK_SQ;
        end
    end

    // Stage 3: registered colour and syncs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vga_r      <= 3'd0;
            vga_g      <= 3'd0;
            vga_b      <= 2'd0;
            vga_hsync  <= 1'b1;
            vga_vsync  <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vga_r      <= pix_s.r;
            vga_g      <= pix_s.g;
            vga_b      <= pix_s.b;
            vga_hsync  <= hs2_r;
            vga_vsync  <= vs2_r;
            frame_tick <= tick2_r;
        end
    end

    // Overlay inputs are sampled once per frame, in vertical blank, so a frame never tears.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cursor_lat_r   <= 6'd0;
            selected_lat_r <= 6'd0;
            hilite_lat_r   <= 1'b0;
        end else if (frame_tick) begin
            cursor_lat_r   <= cursor_addr;
            selected_lat_r <= selected_piece_addr;
            hilite_lat_r   <= hilite_selected_square;
        end
    end

endmodule
